// File: rtl/load_store_unit.sv
// load_store_unit
//   Byte/half/word load-store sequencer in front of a word-wide, big-endian
//   memory with a combinational read port and a posedge write port.
//   Sub-word stores are done as read-modify-write: read in ACCESS, merged
//   word written in MERGE.
//
//   Optional feature: define LSU_ALIGN_CHECK_EN to compile in alignment
//   checking. A misaligned half/word request is answered in the cycle after
//   acceptance with misalign_err=1 and never reaches memory. Without the
//   macro, misalign_err is tied low and the low address bits that do not
//   select a lane are ignored.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   req_valid/ready   request handshake (accepted when both high)
//   req_write         1 = store, 0 = load
//   req_size          00 byte, 01 half, 10/11 word
//   req_unsigned      zero-extend loads instead of sign-extending
//   req_addr          byte address
//   req_wdata         store data, right-justified for byte/half
//   resp_valid        one-cycle completion pulse
//   resp_rdata        last load result (held across stores)
//   misalign_err      qualifies resp_valid
//   mem_address       word-aligned memory address
//   mem_write_data    memory write word
//   mem_MemWrite      memory write enable (write happens on posedge)
//   mem_MemRead       memory read strobe
//   mem_read_data     combinational memory read word
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        misalign_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_MemWrite,
  output logic        mem_MemRead,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2
  } state_t;

  state_t      state_q, state_d;

  logic [1:0]  addr_lo_q;
  logic [1:0]  size_q;
  logic        write_q;
  logic        unsigned_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] rdata_q;
  logic        resp_valid_q;

  logic        accept;
  logic        req_misaligned;
  logic        sub_word_q;

  // Extract the addressed byte/half lane (big-endian) and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  lo,
                                               input logic [1:0]  size,
                                               input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = '0;
    case (lo)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = lo[1] ? word[15:0] : word[31:16];
    case (size)
      2'b00:   load_extract = uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   load_extract = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: load_extract = word;
    endcase
  endfunction

  // Replace only the addressed lane(s) of the old word with store data.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [1:0]  lo,
                                              input logic [1:0]  size,
                                              input logic [31:0] wdata);
    logic [31:0] m;
    m = word;
    case (size)
      2'b00: begin
        case (lo)
          2'd0:    m[31:24] = wdata[7:0];
          2'd1:    m[23:16] = wdata[7:0];
          2'd2:    m[15:8]  = wdata[7:0];
          default: m[7:0]   = wdata[7:0];
        endcase
      end
      2'b01: begin
        if (lo[1]) m[15:0]  = wdata[15:0];
        else       m[31:16] = wdata[15:0];
      end
      default: m = wdata;
    endcase
    store_merge = m;
  endfunction

  assign req_ready  = (state_q == IDLE) && !reset;
  assign accept     = req_valid && req_ready;
  assign sub_word_q = (size_q == 2'b00) || (size_q == 2'b01);

`ifdef LSU_ALIGN_CHECK_EN
  logic misalign_q;

  assign req_misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                          (req_size[1] && (req_addr[1:0] != 2'b00));
  assign misalign_err   = misalign_q && !reset;

  always_ff @(posedge clk) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= accept && req_misaligned;
  end
`else
  assign req_misaligned = 1'b0;
  assign misalign_err   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !req_misaligned) state_d = ACCESS;
      ACCESS:  state_d = (write_q && sub_word_q) ? MERGE : IDLE;
      MERGE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (reset) state_d = IDLE;
  end

  // Strobes come straight from the state and are gated by reset so that a
  // reset raised mid-cycle suppresses the pending posedge write.
  assign mem_MemRead  = (state_q == ACCESS) && !reset;
  assign mem_MemWrite = !reset &&
                        (((state_q == ACCESS) && write_q && !sub_word_q) ||
                         (state_q == MERGE));

  assign resp_valid     = resp_valid_q && !reset;
  assign resp_rdata     = reset ? '0 : rdata_q;
  assign mem_address    = reset ? '0 : mem_addr_q;
  assign mem_write_data = reset ? '0 : mem_wdata_q;

  always_ff @(posedge clk) begin
    state_q <= state_d;
    if (reset) begin
      addr_lo_q    <= '0;
      size_q       <= '0;
      write_q      <= 1'b0;
      unsigned_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rdata_q      <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_lo_q  <= req_addr[1:0];
            size_q     <= req_size;
            write_q    <= req_write;
            unsigned_q <= req_unsigned;
            if (req_misaligned) begin
              resp_valid_q <= 1'b1;
            end else begin
              mem_addr_q <= {req_addr[31:2], 2'b00};
              // Store data lives in the write-data register until the
              // merged word replaces it for sub-word stores.
              if (req_write) mem_wdata_q <= req_wdata;
            end
          end
        end
        ACCESS: begin
          if (!write_q) begin
            rdata_q      <= load_extract(mem_read_data, addr_lo_q, size_q, unsigned_q);
            resp_valid_q <= 1'b1;
          end else if (sub_word_q) begin
            // Merge is formed while the old word is on the read port and
            // captured directly as the word to write in MERGE.
            mem_wdata_q <= store_merge(mem_read_data, addr_lo_q, size_q, mem_wdata_q);
          end else begin
            resp_valid_q <= 1'b1;
          end
        end
        MERGE: begin
          resp_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        misalign_err;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_MemWrite;
  logic        mem_MemRead;
  logic [31:0] mem_read_data;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_write     (req_write),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_ready     (req_ready),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .misalign_err  (misalign_err),
    .mem_address   (mem_address),
    .mem_write_data(mem_write_data),
    .mem_MemWrite  (mem_MemWrite),
    .mem_MemRead   (mem_MemRead),
    .mem_read_data (mem_read_data)
  );

  // Memory model: 16 words, Mem[i]=i byte-wise, big-endian.
  logic [31:0] mem [0:15];
  logic        mem_init;

  assign mem_read_data = mem[mem_address[5:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++)
        mem[i] <= {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    end else if (mem_MemWrite) begin
      mem[mem_address[5:2]] <= mem_write_data;
    end
  end

  int rd_cnt = 0;
  int wr_cnt = 0;
  int resp_cnt = 0;

  always @(posedge clk) begin
    if (mem_MemRead)  rd_cnt++;
    if (mem_MemWrite) wr_cnt++;
    if (resp_valid)   resp_cnt++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
    logic        exp_err;
    int          exp_rd;
    int          exp_wr;
    int          widx;
    logic [31:0] exp_word;
  } vec_t;

  task automatic reload_mem();
    @(negedge clk);
    mem_init = 1'b1;
    @(posedge clk);
    #1 mem_init = 1'b0;
  endtask

  // Issue one request and wait (bounded) for its response.
  // lat counts cycles from acceptance: 1 = response right after accept edge.
  task automatic do_op(input vec_t v, output int lat, output int nrd,
                       output int nwr, output logic err, output logic rdy);
    int rd0, wr0;
    @(negedge clk);
    req_write    = v.wr;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    req_valid    = 1'b1;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!resp_valid) lat = 99;
    err = misalign_err;
    rdy = req_ready;
    nrd = rd_cnt - rd0;
    nwr = wr_cnt - wr0;
  endtask

  localparam int NV = 17;
  vec_t vecs [NV];

  initial begin
    int          lat, nrd, nwr, r0, w0, p0;
    logic        err, rdy;
    logic [31:0] exp_maddr;

    //              wr    sz     uns   addr   wdata         rdata        lat err rd wr widx word
    vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'd4,  32'h0,        32'h04050607, 2, 1'b0, 1, 0, -1, 32'h0};
    vecs[1]  = '{1'b1, 2'b00, 1'b0, 32'd6,  32'hFFFFFF80, 32'h04050607, 3, 1'b0, 1, 1,  1, 32'h04058007};
    vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'd6,  32'h0,        32'hFFFFFF80, 2, 1'b0, 1, 0, -1, 32'h0};
    vecs[3]  = '{1'b0, 2'b00, 1'b1, 32'd6,  32'h0,        32'h00000080, 2, 1'b0, 1, 0, -1, 32'h0};
    vecs[4]  = '{1'b1, 2'b01, 1'b0, 32'd2,  32'h0000BEEF, 32'h00000080, 3, 1'b0, 1, 1,  0, 32'h0001BEEF};
    vecs[5]  = '{1'b0, 2'b01, 1'b0, 32'd2,  32'h0,        32'hFFFFBEEF, 2, 1'b0, 1, 0, -1, 32'h0};
    vecs[6]  = '{1'b0, 2'b01, 1'b1, 32'd2,  32'h0,        32'h0000BEEF, 2, 1'b0, 1, 0, -1, 32'h0};
    vecs[7]  = '{1'b0, 2'b10, 1'b0, 32'd12, 32'h0,        32'h0C0D0E0F, 2, 1'b0, 1, 0, -1, 32'h0};
    vecs[8]  = '{1'b1, 2'b10, 1'b0, 32'd12, 32'hDEADBEEF, 32'h0C0D0E0F, 2, 1'b0, 1, 1,  3, 32'hDEADBEEF};
    vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'd12, 32'h0,        32'hDEADBEEF, 2, 1'b0, 1, 0, -1, 32'h0};
    vecs[10] = '{1'b0, 2'b00, 1'b0, 32'd8,  32'h0,        32'h00000008, 2, 1'b0, 1, 0, -1, 32'h0};
    vecs[11] = '{1'b0, 2'b00, 1'b0, 32'd11, 32'h0,        32'h0000000B, 2, 1'b0, 1, 0, -1, 32'h0};
    vecs[12] = '{1'b0, 2'b01, 1'b0, 32'd8,  32'h0,        32'h00000809, 2, 1'b0, 1, 0, -1, 32'h0};
    vecs[13] = '{1'b0, 2'b11, 1'b0, 32'd16, 32'h0,        32'h10111213, 2, 1'b0, 1, 0, -1, 32'h0};
`ifdef LSU_ALIGN_CHECK_EN
    vecs[14] = '{1'b0, 2'b10, 1'b0, 32'd5,  32'h0,        32'h10111213, 1, 1'b1, 0, 0, -1, 32'h0};
    vecs[15] = '{1'b0, 2'b01, 1'b0, 32'd6,  32'h0,        32'hFFFF8007, 2, 1'b0, 1, 0, -1, 32'h0};
    vecs[16] = '{1'b0, 2'b01, 1'b1, 32'd7,  32'h0,        32'hFFFF8007, 1, 1'b1, 0, 0, -1, 32'h0};
`else
    vecs[14] = '{1'b0, 2'b10, 1'b0, 32'd5,  32'h0,        32'h04058007, 2, 1'b0, 1, 0, -1, 32'h0};
    vecs[15] = '{1'b0, 2'b01, 1'b0, 32'd6,  32'h0,        32'hFFFF8007, 2, 1'b0, 1, 0, -1, 32'h0};
    vecs[16] = '{1'b0, 2'b01, 1'b1, 32'd7,  32'h0,        32'h00008007, 2, 1'b0, 1, 0, -1, 32'h0};
`endif

    // Reset with req_valid held high: nothing may be accepted.
    reset        = 1'b1;
    mem_init     = 1'b1;
    req_valid    = 1'b1;
    req_write    = 1'b0;
    req_size     = 2'b10;
    req_unsigned = 1'b0;
    req_addr     = 32'd4;
    req_wdata    = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_req_ready",   32'(req_ready),    32'd0);
    check("reset_resp_valid",  32'(resp_valid),   32'd0);
    check("reset_resp_rdata",  resp_rdata,        32'd0);
    check("reset_misalign",    32'(misalign_err), 32'd0);
    check("reset_mem_address", mem_address,       32'd0);
    check("reset_mem_wdata",   mem_write_data,    32'd0);
    check("reset_memwrite",    32'(mem_MemWrite), 32'd0);
    check("reset_memread",     32'(mem_MemRead),  32'd0);
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 1'b0;
    mem_init  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("post_reset_ready",     32'(req_ready), 32'd1);
    check("post_reset_no_read",   32'(rd_cnt),    32'd0);
    check("post_reset_no_resp",   32'(resp_cnt),  32'd0);

    // Back-to-back loads with req_valid held: accepts two cycles apart.
    @(negedge clk);
    req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr  = 32'd0; req_valid = 1'b1;
    @(posedge clk); #1;
    check("b2b_busy_after_accept", 32'(req_ready), 32'd0);
    req_addr = 32'd8;
    @(posedge clk); #1;
    check("b2b_resp0_valid", 32'(resp_valid), 32'd1);
    check("b2b_resp0_data",  resp_rdata,      32'h00010203);
    check("b2b_resp0_ready", 32'(req_ready),  32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("b2b_second_accepted", 32'(req_ready),  32'd0);
    check("b2b_gap_no_resp",     32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    check("b2b_resp1_valid", 32'(resp_valid), 32'd1);
    check("b2b_resp1_data",  resp_rdata,      32'h08090A0B);

    // Reset during MERGE of a half store abandons it.
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    req_addr = 32'd0;
`else
    req_addr = 32'd1;
`endif
    req_wdata = 32'h00001234; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("merge_write_pending", 32'(mem_MemWrite), 32'd1);
    w0 = wr_cnt;
    p0 = resp_cnt;
    reset = 1'b1;
    #1;
    check("merge_reset_no_write", 32'(mem_MemWrite), 32'd0);
    check("merge_reset_not_ready", 32'(req_ready),   32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("merge_reset_ready_after", 32'(req_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("merge_reset_write_cnt", 32'(wr_cnt - w0),   32'd0);
    check("merge_reset_resp_cnt",  32'(resp_cnt - p0), 32'd0);
    check("merge_reset_word0",     mem[0],             32'h00010203);

    // Table-driven vectors on freshly loaded memory.
    reload_mem();
    r0 = 0;
    exp_maddr = 32'd0;
    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i], lat, nrd, nwr, err, rdy);
      if (!vecs[i].exp_err) exp_maddr = {vecs[i].addr[31:2], 2'b00};
      check($sformatf("v%0d_latency", i),  32'(lat),   32'(vecs[i].exp_lat));
      check($sformatf("v%0d_rdata", i),    resp_rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_misalign", i), 32'(err),   32'(vecs[i].exp_err));
      check($sformatf("v%0d_reads", i),    32'(nrd),   32'(vecs[i].exp_rd));
      check($sformatf("v%0d_writes", i),   32'(nwr),   32'(vecs[i].exp_wr));
      check($sformatf("v%0d_ready", i),    32'(rdy),   32'd1);
      check($sformatf("v%0d_mem_addr", i), mem_address, exp_maddr);
      if (vecs[i].widx >= 0)
        check($sformatf("v%0d_mem_word", i), mem[vecs[i].widx], vecs[i].exp_word);
      @(posedge clk); #1;
      check($sformatf("v%0d_pulse_end", i), 32'(resp_valid), 32'd0);
      check($sformatf("v%0d_rdata_hold", i), resp_rdata,     vecs[i].exp_rdata);
      r0++;
    end
    check("vectors_applied", 32'(r0), 32'(NV));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
